// File: rtl/playfield_engine.sv
// playfield_engine: COLS x ROWS Tetris occupancy grid with piece commit,
// full-row detection, shift-down line clearing, scoring and game-over.
// Optional macro PLAYFIELD_COMBO_EN adds a saturating combo bonus to the score.
module playfield_engine #(
  parameter int COLS    = 10,
  parameter int ROWS    = 10,
  parameter int SCORE_W = 32,
  localparam int IDXW   = $clog2(COLS*ROWS)
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  restart,
  input  logic                  lock_valid,
  output logic                  lock_ready,
  input  logic [4*IDXW-1:0]     lock_cells,
  output logic [0:COLS*ROWS-1]  field,
  output logic [SCORE_W-1:0]    score,
  output logic [2:0]            lines,
  output logic                  game_over
);

  localparam int CELLS = COLS * ROWS;
  localparam int RW    = $clog2(ROWS);
  localparam logic [IDXW:0] CELLS_W = (IDXW+1)'(CELLS);

  typedef enum logic [2:0] {IDLE, WRITE, SCAN, SHIFT, SCORE, OVER} state_t;

  state_t              state, next_state;
  logic [4*IDXW-1:0]   cells_q;
  logic [RW-1:0]       row_q;
  logic [2:0]          cnt_q;
  logic [IDXW-1:0]     cell_idx [4];
  logic [0:CELLS-1]    write_mask;
  logic [0:CELLS-1]    shifted;
  logic                overlap;
  logic                row_full;
  logic                above_full;
  logic [4:0]          bonus;

  // Points awarded for the number of rows cleared by one lock
  function automatic logic [4:0] points(input logic [2:0] c);
    case (c)
      3'd1:    points = 5'd1;
      3'd2:    points = 5'd3;
      3'd3:    points = 5'd5;
      3'd4:    points = 5'd8;
      default: points = 5'd0;
    endcase
  endfunction

  // Score addition clamped at the all-ones maximum
  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                 input logic [4:0] b);
    logic [SCORE_W:0] s;
    s = {1'b0, a} + (SCORE_W+1)'(b);
    sat_add = s[SCORE_W] ? {SCORE_W{1'b1}} : s[SCORE_W-1:0];
  endfunction

`ifdef PLAYFIELD_COMBO_EN
  logic [3:0] combo_q;

  // Consecutive clearing-lock streak, saturating at 15; the pre-increment value is the bonus
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)                combo_q <= '0;
    else if (restart)           combo_q <= '0;
    else if (state == SCORE)    combo_q <= (cnt_q == 3'd0) ? 4'd0 :
                                           (combo_q == 4'hf) ? 4'hf : combo_q + 4'd1;
  end

  assign bonus = {1'b0, combo_q};
`else
  assign bonus = 5'd0;
`endif

  // Decode the latched cells into a write mask and detect collisions with the field
  always_comb begin
    overlap    = 1'b0;
    write_mask = '0;
    for (int k = 0; k < 4; k++) begin
      cell_idx[k] = cells_q[k*IDXW +: IDXW];
      if ({1'b0, cell_idx[k]} < CELLS_W) begin
        write_mask[cell_idx[k]] = 1'b1;
        if (field[cell_idx[k]]) overlap = 1'b1;
      end
    end
  end

  // Row-full tests for the current row and the row above it, plus the shifted field image
  always_comb begin
    int base_r;
    int base_a;
    base_r     = int'(row_q) * COLS;
    base_a     = (row_q == '0) ? 0 : base_r - COLS;
    row_full   = &field[base_r +: COLS];
    above_full = (row_q != '0) && (&field[base_a +: COLS]);
    shifted    = field;
    shifted[0 +: COLS] = '0;
    for (int i = 1; i < ROWS; i++) begin
      if (i <= int'(row_q)) shifted[i*COLS +: COLS] = field[(i-1)*COLS +: COLS];
    end
  end

  // State register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= next_state;
  end

  // Next-state logic; a shift also rescans the row that just moved into place
  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (lock_valid) next_state = WRITE;
      WRITE: next_state = overlap ? OVER : SCAN;
      SCAN:  if (row_full)          next_state = SHIFT;
             else if (row_q == '0)  next_state = SCORE;
      SHIFT: if (above_full)        next_state = SHIFT;
             else if (row_q == '0)  next_state = SCORE;
             else                   next_state = SCAN;
      SCORE: next_state = IDLE;
      OVER:  next_state = OVER;
      default: next_state = IDLE;
    endcase
    if (restart) next_state = IDLE;
  end

  // Field, score, line count and scan bookkeeping
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      field      <= '0;
      score      <= '0;
      lines      <= '0;
      game_over  <= 1'b0;
      lock_ready <= 1'b1;
      cells_q    <= '0;
      row_q      <= '0;
      cnt_q      <= '0;
    end else if (restart) begin
      field      <= '0;
      score      <= '0;
      lines      <= '0;
      game_over  <= 1'b0;
      lock_ready <= 1'b1;
    end else begin
      lock_ready <= (next_state == IDLE);
      case (state)
        IDLE:  if (lock_valid) cells_q <= lock_cells;
        WRITE: begin
          if (overlap) begin
            game_over <= 1'b1;
          end else begin
            field <= field | write_mask;
            row_q <= RW'(ROWS-1);
            cnt_q <= 3'd0;
          end
        end
        SCAN:  if (!row_full && row_q != '0) row_q <= row_q - 1'b1;
        SHIFT: begin
          field <= shifted;
          cnt_q <= cnt_q + 3'd1;
          if (!above_full && row_q != '0) row_q <= row_q - 1'b1;
        end
        SCORE: begin
          lines <= cnt_q;
          score <= sat_add(score, points(cnt_q) + bonus);
        end
        default: ;
      endcase
    end
  end

endmodule
